// File: rtl/cpu_alu_pkg.sv
// Shared types and constants for the two-stage ALU pipeline.
package cpu_alu_pkg;

  typedef enum logic [2:0] {
    OP_PASS_A = 3'b000,
    OP_PASS_B = 3'b001,
    OP_XOR    = 3'b010,
    OP_XNOR   = 3'b011,
    OP_ADD    = 3'b100,
    OP_SUB    = 3'b101,
    OP_SHL    = 3'b110,
    OP_SHR    = 3'b111
  } opcode_e;

  // Packed so that z lands in the MSB: {Z,N,C,V}.
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cpu_alu_core.sv
// Combinational ALU datapath: result and {Z,N,C,V} flags from two operands.
module cpu_alu_core
  import cpu_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  opcode_e          op;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;
  flags_t           f;

  assign op   = opcode_e'(opcode);
  // Extra top bit holds carry-out for ADD and borrow for SUB.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Select the operation result plus carry and overflow.
  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_PASS_A: res = a;
      OP_PASS_B: res = b;
      OP_XOR:    res = a ^ b;
      OP_XNOR:   res = ~(a ^ b);
      OP_ADD: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff[WIDTH-1:0];
        carry = diff[WIDTH];
        ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL: begin
        res   = {a[WIDTH-2:0], 1'b0};
        carry = a[WIDTH-1];
      end
      OP_SHR: begin
        res   = {1'b0, a[WIDTH-1:1]};
        carry = a[0];
      end
      default: res = '0;
    endcase
  end

  // Pack the status flags from the selected result.
  always_comb begin
    f.z = (res == '0);
    f.n = res[WIDTH-1];
    f.c = carry;
    f.v = ovf;
  end

  assign result = res;
  assign flags  = f;

endmodule

// File: rtl/cpu_alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 registers the request, S2 the
// computed result and flags; an optional accumulator feeds back as operand A.
module cpu_alu_pipe
  import cpu_alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ACC_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [WIDTH-1:0] acc
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s1_use_acc;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic [3:0]       s2_flags;
  logic [WIDTH-1:0] acc_q;

  logic             s2_load;
  logic             s1_accept;
  logic [WIDTH-1:0] eff_a;
  logic [WIDTH-1:0] core_result;
  logic [3:0]       core_flags;

  // S2 takes S1 whenever it is empty or being drained this cycle; in_ready
  // follows combinationally so a full pipeline still streams one per cycle.
  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s2_load;
  assign s1_accept = in_valid && in_ready;

  // The accumulator always holds the result of the most recent S1->S2
  // transfer, so a use_acc request directly behind its producer sees it.
  assign eff_a = ((ACC_EN != 0) && s1_use_acc) ? acc_q : s1_a;

  cpu_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (eff_a),
    .b      (s1_b),
    .opcode (s1_op),
    .result (core_result),
    .flags  (core_flags)
  );

  // Stage 1: capture an accepted request, empty when it moves on to S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= '0;
      s1_use_acc <= 1'b0;
    end else if (s1_accept) begin
      s1_valid   <= 1'b1;
      s1_a       <= a;
      s1_b       <= b;
      s1_op      <= opcode;
      s1_use_acc <= use_acc;
    end else if (s2_load) begin
      s1_valid   <= 1'b0;
    end
  end

  // Stage 2: register the computed result; hold it while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_flags  <= '0;
    end else if (s2_load) begin
      s2_valid  <= 1'b1;
      s2_result <= core_result;
      s2_flags  <= core_flags;
    end else if (out_ready) begin
      s2_valid  <= 1'b0;
    end
  end

  // Accumulator: follows every S1->S2 transfer, pinned to zero when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if ((ACC_EN != 0) && s2_load) begin
      acc_q <= core_result;
    end
  end

  assign out_valid = s2_valid;
  assign result    = s2_result;
  assign flags     = s2_flags;
  assign acc       = acc_q;

endmodule

// File: doc/cpu_alu_pipe.md
CPU_ALU_PIPE -- requirements
Module: cpu_alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal range 4..64).
REQ-002 Parameter ACC_EN, default 1, enables the accumulator feedback path (0: use_acc ignored, acc held at 0).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  request presented.
REQ-006 in_ready  output  1  block accepts the request this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 opcode  input  3  operation select.
REQ-010 use_acc  input  1  substitute the accumulator for operand A.
REQ-011 out_valid  output  1  result and flags valid.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 result  output  WIDTH  operation result.
REQ-014 flags  output  4  {Z,N,C,V}, MSB first.
REQ-015 acc  output  WIDTH  current accumulator value.

Function
REQ-016 Opcodes SHALL be: 000 PASS_A, 001 PASS_B, 010 XOR, 011 XNOR, 100 ADD, 101 SUB (A-B), 110 SHL by 1 (zero fill), 111 SHR by 1 (logical, zero fill).
REQ-017 Results SHALL be truncated modulo 2^WIDTH.
REQ-018 Transfers SHALL occur only when valid and ready are both high on the same edge.
REQ-019 Pipeline SHALL be two registered stages: S1 holds the operands, opcode and use_acc; S2 holds the result and flags.
REQ-020 Latency SHALL be exactly 2 cycles from input accept to out_valid when out_ready stays high, with a throughput of one result per cycle.
REQ-021 Stage-advance rules:
 - S2 SHALL load when S1 is valid and (S2 is empty or out_ready is high).
 - in_ready SHALL equal (S1 empty or S1 advancing) and SHALL be combinational from out_ready, with no register bubble.
REQ-022 Compute SHALL take place on the S1->S2 transfer; the effective A SHALL be acc when use_acc=1 and ACC_EN=1, else the A held in S1.
REQ-023 acc SHALL load the computed result on every S1->S2 transfer, so back-to-back use_acc requests see the immediately preceding result with no hazard.
REQ-024 Flag Z SHALL be set when result==0.
REQ-025 Flag N SHALL equal result[WIDTH-1].
REQ-026 Flag C:
 - ADD: carry-out.
 - SUB: borrow (A<B unsigned).
 - SHL: A[WIDTH-1].
 - SHR: A[0].
 - Otherwise 0.
REQ-027 Flag V SHALL be signed overflow for ADD/SUB and 0 otherwise.
REQ-028 Under out_valid=1 and out_ready=0, result and flags SHALL hold stable; S1 SHALL hold once S2 is full; no request is dropped or duplicated, and order is preserved.
REQ-029 When S2 drains and S1 loads on the same edge, both transfers SHALL complete.
REQ-030 in_valid/a/b/opcode/use_acc SHALL be don't-care when in_ready=0 or in_valid=0.

Reset
REQ-031 While rst_n=0, asynchronously:
 - S1 and S2 valid bits clear, so out_valid=0 and in_ready=1 after release.
 - result=0, flags=0, acc=0.
REQ-032 A reset mid-operation SHALL discard all in-flight requests with no partial output.
REQ-033 The first accept SHALL be possible on the first rising edge with rst_n=1.

Structure
REQ-034 Package cpu_alu_pkg SHALL hold:
 - the opcode enum (3-bit, encodings per REQ-016);
 - the flags struct {z,n,c,v};
 - flag bit-index constants.
REQ-035 Combinational compute SHALL reside in the sub-module cpu_alu_core (parameter WIDTH; inputs a, b, opcode; outputs result, flags), instantiated once between S1 and S2.

Verification (WIDTH=8)
REQ-036 ADD a=0x7F b=0x01 -> result 0x80, flags Z0 N1 C0 V1, out_valid exactly 2 cycles after accept.
REQ-037 SUB a=0x00 b=0x01 -> result 0xFF, flags Z0 N1 C1 V0; SHR a=0x01 -> result 0x00, flags Z1 C1.
REQ-038 ADD 5+3, then use_acc=1 ADD b=2 on the next cycle -> results 0x08 then 0x0A, acc=0x0A.
REQ-039 Stream 4 requests with out_ready=0 for 4 cycles -> in_ready falls after 2 accepts, result holds; on out_ready=1, all 4 emerge in order with no gaps.
REQ-040 Assert rst_n=0 with both stages full -> out_valid, result, flags and acc read 0 before the next clock edge; after release, nothing stale is emitted.
